// File: rtl/kw_pkg.sv
// Shared types, keyword constants and character helpers for the keyword
// nesting checker.
package kw_pkg;

  // Longest keyword ("endcase") in letters; the classifier keeps this many.
  localparam int MAX_KW_LEN = 7;
  localparam int WORD_W     = 8 * MAX_KW_LEN;

  // Word-length counter saturates here so "endcasex" cannot alias "endcase".
  localparam logic [3:0] LEN_SAT = 4'd8;

  typedef enum logic {
    KIND_BEGIN = 1'b0,
    KIND_CASE  = 1'b1
  } kind_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_UNDER    = 2'd1,
    ERR_MISMATCH = 2'd2,
    ERR_OVER     = 2'd3
  } err_code_t;

  // Keywords packed first-letter-in-LSB, zero padded above their length.
  localparam logic [WORD_W-1:0] KW_BEGIN   = 56'h00_00_6e_69_67_65_62;
  localparam logic [WORD_W-1:0] KW_CASE    = 56'h00_00_00_65_73_61_63;
  localparam logic [WORD_W-1:0] KW_END     = 56'h00_00_00_00_64_6e_65;
  localparam logic [WORD_W-1:0] KW_ENDCASE = 56'h65_73_61_63_64_6e_65;

  localparam logic [3:0] KW_BEGIN_LEN   = 4'd5;
  localparam logic [3:0] KW_CASE_LEN    = 4'd4;
  localparam logic [3:0] KW_END_LEN     = 4'd3;
  localparam logic [3:0] KW_ENDCASE_LEN = 4'd7;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5a)) || ((c >= 8'h61) && (c <= 8'h7a));
  endfunction

  function automatic logic [7:0] fold_lower(input logic [7:0] c);
    logic [7:0] r;
    if ((c >= 8'h41) && (c <= 8'h5a)) begin
      r = c | 8'h20;
    end else begin
      r = c;
    end
    return r;
  endfunction

endpackage

// File: rtl/kw_word_classifier.sv
// Collects letters into a word and classifies it as an open/close keyword
// in the same cycle its terminating delimiter is presented.
module kw_word_classifier
  import kw_pkg::*;
#(
  parameter logic [1:0] PAIR_EN = 2'b11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in,
  output logic       word_done,
  output logic       is_open,
  output logic       is_close,
  output kind_t      kind
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [3:0]        len_q, len_d;
  logic              letter_s;
  logic [7:0]        lc_s;
  logic              hit_begin_s, hit_case_s, hit_end_s, hit_endcase_s;

  // Next word buffer: append folded letters, clear on any delimiter.
  always_comb begin
    word_d   = word_q;
    len_d    = len_q;
    letter_s = is_letter(in);
    lc_s     = fold_lower(in);
    if (in_valid) begin
      if (letter_s) begin
        for (int i = 0; i < MAX_KW_LEN; i++) begin
          if (len_q == 4'(i)) begin
            word_d[8*i +: 8] = lc_s;
          end else begin
            word_d[8*i +: 8] = word_q[8*i +: 8];
          end
        end
        if (len_q == LEN_SAT) begin
          len_d = len_q;
        end else begin
          len_d = len_q + 4'd1;
        end
      end else begin
        word_d = {WORD_W{1'b0}};
        len_d  = 4'd0;
      end
    end else begin
      word_d = word_q;
      len_d  = len_q;
    end
  end

  // Word buffer and length registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= {WORD_W{1'b0}};
      len_q  <= 4'd0;
    end else begin
      word_q <= word_d;
      len_q  <= len_d;
    end
  end

  // Whole-word keyword match on the delimiter cycle; the buffer holds the
  // completed word until the delimiter clock edge clears it.
  always_comb begin
    word_done     = in_valid && !letter_s && (len_q != 4'd0);
    hit_begin_s   = PAIR_EN[0] && (len_q == KW_BEGIN_LEN)   && (word_q == KW_BEGIN);
    hit_end_s     = PAIR_EN[0] && (len_q == KW_END_LEN)     && (word_q == KW_END);
    hit_case_s    = PAIR_EN[1] && (len_q == KW_CASE_LEN)    && (word_q == KW_CASE);
    hit_endcase_s = PAIR_EN[1] && (len_q == KW_ENDCASE_LEN) && (word_q == KW_ENDCASE);
    is_open       = word_done && (hit_begin_s || hit_case_s);
    is_close      = word_done && (hit_end_s || hit_endcase_s);
    if (hit_case_s || hit_endcase_s) begin
      kind = KIND_CASE;
    end else begin
      kind = KIND_BEGIN;
    end
  end

endmodule

// File: rtl/keyword_nest_checker.sv
// Streaming checker for nested begin/end and case/endcase pairs with a
// bounded kind stack and sticky first-error reporting.
module keyword_nest_checker
  import kw_pkg::*;
#(
  parameter int         DEPTH   = 16,
  parameter logic [1:0] PAIR_EN = 2'b11,
  localparam int        DW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in,
  output logic          result,
  output logic [DW-1:0] depth,
  output logic          error,
  output logic [1:0]    err_code
);

  logic             word_done_s, is_open_s, is_close_s;
  kind_t            kind_s;
  logic [DEPTH-1:0] stack_q, stack_d;
  logic [DW-1:0]    ptr_q, ptr_d;
  logic             error_q, error_d;
  err_code_t        code_q, code_d;
  logic             top_s;

  kw_word_classifier #(
    .PAIR_EN (PAIR_EN)
  ) u_classifier (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in        (in),
    .word_done (word_done_s),
    .is_open   (is_open_s),
    .is_close  (is_close_s),
    .kind      (kind_s)
  );

  // Kind currently on top of the stack (entry ptr-1); 0 when empty.
  always_comb begin
    top_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ptr_q == DW'(i + 1)) begin
        top_s = stack_q[i];
      end else begin
        top_s = top_s;
      end
    end
  end

  // Push/pop/error decision; nothing moves once an error is latched.
  always_comb begin
    stack_d = stack_q;
    ptr_d   = ptr_q;
    error_d = error_q;
    code_d  = code_q;
    if (!error_q && word_done_s) begin
      if (is_open_s) begin
        if (ptr_q == DW'(DEPTH)) begin
          error_d = 1'b1;
          code_d  = ERR_OVER;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (ptr_q == DW'(i)) begin
              stack_d[i] = kind_s;
            end else begin
              stack_d[i] = stack_q[i];
            end
          end
          ptr_d = ptr_q + DW'(1);
        end
      end else if (is_close_s) begin
        if (ptr_q == DW'(0)) begin
          error_d = 1'b1;
          code_d  = ERR_UNDER;
        end else if (top_s != kind_s) begin
          error_d = 1'b1;
          code_d  = ERR_MISMATCH;
        end else begin
          ptr_d = ptr_q - DW'(1);
        end
      end else begin
        ptr_d = ptr_q;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Stack contents are not reset; only the pointer defines what is live.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  // Pointer and error state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= DW'(0);
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      ptr_q   <= ptr_d;
      error_q <= error_d;
      code_q  <= code_d;
    end
  end

  assign result   = !error_q && (ptr_q == DW'(0));
  assign depth    = ptr_q;
  assign error    = error_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_keyword_nest_checker.sv
// Scoreboard bench: three checker instances (default, DEPTH=4, begin/end only)
// share a stimulus stream gated by a select; expected outputs are queued at
// stimulus time and compared by an independent monitor.
module tb_keyword_nest_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_c = 8'h00;
  int         sel = 0;
  logic       chk_flag = 1'b0;

  logic       v0, v1, v2;
  logic       r0, r1, r2, e0, e1, e2;
  logic [4:0] d0, d2;
  logic [2:0] d1;
  logic [1:0] c0, c1, c2;

  typedef struct {
    int         sel;
    logic [8:0] val;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  assign v0 = in_valid && (sel == 0);
  assign v1 = in_valid && (sel == 1);
  assign v2 = in_valid && (sel == 2);

  keyword_nest_checker u_dut0 (
    .clk(clk), .reset(reset), .in_valid(v0), .in(in_c),
    .result(r0), .depth(d0), .error(e0), .err_code(c0)
  );

  keyword_nest_checker #(.DEPTH(4)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in(in_c),
    .result(r1), .depth(d1), .error(e1), .err_code(c1)
  );

  keyword_nest_checker #(.PAIR_EN(2'b01)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in(in_c),
    .result(r2), .depth(d2), .error(e2), .err_code(c2)
  );

  function automatic logic [8:0] pk(input logic res, input int dep, input logic err, input int code);
    return {res, 5'(dep), err, 2'(code)};
  endfunction

  // Monitor: whenever a checked cycle is clocked, pop and compare.
  initial begin
    forever begin
      logic f;
      exp_t e;
      logic [8:0] act;
      @(posedge clk);
      f = chk_flag;
      #1;
      if (f) begin
        n_total++;
        if (q.size() == 0) begin
          $display("FAIL scoreboard_empty: check cycle with no expected entry");
        end else begin
          e = q.pop_front();
          case (e.sel)
            0:       act = {r0, d0, e0, c0};
            1:       act = {r1, 2'b00, d1, e1, c1};
            default: act = {r2, d2, e2, c2};
          endcase
          if (act === e.val) begin
            n_pass++;
          end else begin
            $display("FAIL %s: got res=%0b dep=%0d err=%0b code=%0d, want res=%0b dep=%0d err=%0b code=%0d",
                     e.name, act[8], act[7:3], act[2], act[1:0],
                     e.val[8], e.val[7:3], e.val[2], e.val[1:0]);
          end
        end
      end
    end
  end

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b1; in_c = s[i]; chk_flag = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; chk_flag = 1'b0;
  endtask

  task automatic check_char(input logic [7:0] c, input logic [8:0] v, input string name);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b1; in_c = c; chk_flag = 1'b1;
    q.push_back('{sel, v, name});
  endtask

  task automatic check_idle(input logic [8:0] v, input string name);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; chk_flag = 1'b1;
    q.push_back('{sel, v, name});
  endtask

  task automatic rst_chk(input string name);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; chk_flag = 1'b1;
    q.push_back('{sel, pk(1'b1, 0, 1'b0, 0), name});
  endtask

  task automatic select(input int n);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; chk_flag = 1'b0; sel = n;
  endtask

  initial begin
    // Default configuration: balanced nesting.
    select(0);
    rst_chk("reset_state");
    send("begin");   check_char(8'h20, pk(0, 1, 0, 0), "nest_begin");
    send("case");    check_char(8'h20, pk(0, 2, 0, 0), "nest_case");
    send("x ");
    send("endcase"); check_char(8'h20, pk(0, 1, 0, 0), "nest_endcase");
    send("end");     check_char(8'h20, pk(1, 0, 0, 0), "nest_end");

    // Case folding, punctuation delimiter, word without delimiter.
    rst_chk("reset_fold");
    send("BeGiN");   check_char(8'h20, pk(0, 1, 0, 0), "fold_begin");
    send("EnD");     check_char(8'h3b, pk(1, 0, 0, 0), "fold_end_semicolon");
    send("begin");   check_idle(pk(1, 0, 0, 0), "no_delim_yet");
    check_char(8'h20, pk(0, 1, 0, 0), "delim_after_gap");
    send("xend");    check_char(8'h20, pk(0, 1, 0, 0), "xend_plain");
    send("endcasee"); check_char(8'h20, pk(0, 1, 0, 0), "len8_no_match");
    send("end");     check_char(8'h0a, pk(1, 0, 0, 0), "end_newline");

    // Underflow, then sticky.
    rst_chk("reset_under");
    send("end");     check_char(8'h20, pk(0, 0, 1, 1), "underflow");
    send("begin");   check_char(8'h20, pk(0, 0, 1, 1), "underflow_sticky");

    // Mismatches.
    rst_chk("reset_mm1");
    send("begin");   check_char(8'h20, pk(0, 1, 0, 0), "mm1_open");
    send("endcase"); check_char(8'h20, pk(0, 1, 1, 2), "mm1_endcase");
    rst_chk("reset_mm2");
    send("case");    check_char(8'h20, pk(0, 1, 0, 0), "mm2_open");
    send("end");     check_char(8'h20, pk(0, 1, 1, 2), "mm2_end");
    send("endcase"); check_char(8'h20, pk(0, 1, 1, 2), "mm2_frozen");

    // DEPTH=4 overflow and mid-word reset.
    select(1);
    rst_chk("d4_reset");
    for (int k = 1; k <= 4; k++) begin
      send("begin"); check_char(8'h20, pk(0, k, 0, 0), $sformatf("d4_push%0d", k));
    end
    send("begin");   check_char(8'h20, pk(0, 4, 1, 3), "d4_overflow");
    send("end");     check_char(8'h20, pk(0, 4, 1, 3), "d4_overflow_sticky");
    send("beg");
    rst_chk("d4_reset_midword");
    send("in");      check_char(8'h20, pk(1, 0, 0, 0), "d4_partial_discarded");

    // begin/end only.
    select(2);
    rst_chk("pe_reset");
    send("case");    check_char(8'h20, pk(1, 0, 0, 0), "pe_case_ignored");
    send("end");     check_char(8'h20, pk(0, 0, 1, 1), "pe_end_underflow");
    rst_chk("pe_reset2");
    send("beginning"); check_char(8'h20, pk(1, 0, 0, 0), "pe_beginning");
    send("ends");    check_char(8'h20, pk(1, 0, 0, 0), "pe_ends");
    send("be"); idle(); idle();
    send("gin");     check_char(8'h20, pk(0, 1, 0, 0), "pe_gap_begin");
    send("e"); idle();
    send("nd");      check_char(8'h2e, pk(1, 0, 0, 0), "pe_gap_end");

    idle(); idle(); idle();
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_leftover: got %0d pending entries, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
